// File: rtl/cdb_pkg.sv
// Shared common-data-bus packet layout for the CDB scheduler, reservation stations
// and register-status logic.
package cdb_pkg;

    localparam int unsigned REG_W    = 4;
    localparam int unsigned LINE_W   = 3;
    localparam int unsigned VALUE_W  = 16;
    localparam int unsigned RESULT_W = REG_W + LINE_W + VALUE_W;

    localparam int unsigned VALUE_LSB = 0;
    localparam int unsigned LINE_LSB  = VALUE_LSB + VALUE_W;
    localparam int unsigned REG_LSB   = LINE_LSB + LINE_W;

    // Field order matches the wire packing {dest_reg, rs_line, value}.
    typedef struct packed {
        logic [REG_W-1:0]   dest_reg;
        logic [LINE_W-1:0]  rs_line;
        logic [VALUE_W-1:0] value;
    } cdb_result_t;

    function automatic cdb_result_t make_result(
        input logic [REG_W-1:0]   dest_reg,
        input logic [LINE_W-1:0]  rs_line,
        input logic [VALUE_W-1:0] value
    );
        cdb_result_t r;
        r.dest_reg = dest_reg;
        r.rs_line  = rs_line;
        r.value    = value;
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request found
// scanning from ptr upward, wrapping modulo N.
module rr_arbiter #(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

    // Two passes (indices at/above ptr, then below) give the wrapped priority order.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!grant_any && req[i] && (IDX_W'(i) >= ptr)) begin
                grant[i]  = 1'b1;
                grant_idx = IDX_W'(i);
                grant_any = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!grant_any && req[i] && (IDX_W'(i) < ptr)) begin
                grant[i]  = 1'b1;
                grant_idx = IDX_W'(i);
                grant_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus scheduler: one holding slot per functional unit, one round-robin
// broadcast per cycle. Define CDB_BYPASS_EN to let a fresh result go straight to the CDB.
module cdb_arbiter #(
    parameter int unsigned N_UNITS  = 3,
    parameter int unsigned RESULT_W = cdb_pkg::RESULT_W,
    parameter int unsigned SRC_W    = $clog2(N_UNITS)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [N_UNITS-1:0]            fu_done,
    input  logic [N_UNITS*RESULT_W-1:0]   fu_solution,
    output logic [N_UNITS-1:0]            fu_ready,
    output logic                          cdb_valid,
    output logic [RESULT_W-1:0]           cdb_data,
    output logic [SRC_W-1:0]              cdb_src,
    output logic                          overflow
);

    logic [N_UNITS-1:0]  hold_valid;
    logic [RESULT_W-1:0] hold_data [N_UNITS];
    logic [SRC_W-1:0]    rr_ptr;

    logic [N_UNITS-1:0]  cand;
    logic [N_UNITS-1:0]  grant;
    logic [N_UNITS-1:0]  bypass;
    logic [N_UNITS-1:0]  store;
    logic [SRC_W-1:0]    grant_idx;
    logic                grant_any;
    logic                drop;
    logic [RESULT_W-1:0] bcast_data;

    // A slot accepts a new result when empty or when it is being drained this cycle.
    assign fu_ready = ~hold_valid | grant;

`ifdef CDB_BYPASS_EN
    // An empty slot is always ready, so done alone qualifies; this avoids a ready/grant loop.
    assign cand   = hold_valid | fu_done;
    assign bypass = grant & ~hold_valid;
`else
    assign cand   = hold_valid;
    assign bypass = '0;
`endif

    assign store = fu_done & fu_ready & ~bypass;
    assign drop  = |(fu_done & ~fu_ready);

    rr_arbiter #(
        .N     (N_UNITS),
        .IDX_W (SRC_W)
    ) u_rr (
        .req       (cand),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Broadcast source: the held result, or the incoming one when it is bypassed.
    always_comb begin
        bcast_data = '0;
        for (int i = 0; i < N_UNITS; i++) begin
            if (grant[i]) begin
                bcast_data = hold_valid[i] ? hold_data[i]
                                           : fu_solution[i*RESULT_W +: RESULT_W];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cdb_valid  <= 1'b0;
            cdb_data   <= '0;
            cdb_src    <= '0;
            overflow   <= 1'b0;
            hold_valid <= '0;
            rr_ptr     <= '0;
        end else if (flush) begin
            cdb_valid  <= 1'b0;
            hold_valid <= '0;
        end else begin
            cdb_valid <= grant_any;
            if (grant_any) begin
                cdb_data <= bcast_data;
                cdb_src  <= grant_idx;
                rr_ptr   <= (grant_idx == SRC_W'(N_UNITS - 1)) ? '0 : grant_idx + SRC_W'(1);
            end
            hold_valid <= (hold_valid & ~grant) | store;
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Payload storage needs no reset; hold_valid qualifies it.
    always_ff @(posedge clock) begin
        for (int i = 0; i < N_UNITS; i++) begin
            if (!reset && !flush && store[i]) begin
                hold_data[i] <= fu_solution[i*RESULT_W +: RESULT_W];
            end
        end
    end

endmodule
